// File: rtl/cache_bank_double_access.sv
// Two-port shared storage bank: two write ports, where port 1 wins a same-address collision,
// and two registered read ports that return the old contents during a write.
module cache_bank_double_access #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_we,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata,
   input  logic                  i_we2,
   input  logic [DATA_WIDTH-1:0] i_wdata2,
   input  logic [ADDR_WIDTH-1:0] i_waddr2,
   input  logic [ADDR_WIDTH-1:0] i_raddr2,
   output logic [DATA_WIDTH-1:0] o_rdata2
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   generate
      if (DATA_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_bad_params
         $error("cache_bank_double_access: DATA_WIDTH and ADDR_WIDTH must be >= 1");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  we2_eff;

   // Port 2 is masked on a same-address collision so that port 1's data lands.
   assign we2_eff = i_we2 && !(i_we && (i_waddr == i_waddr2));

   // Storage array: no reset, so that it infers as RAM and keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (we2_eff)
            mem[i_waddr2] <= i_wdata2;
         if (i_we)
            mem[i_waddr] <= i_wdata;
      end
   end

   // Read registers sample the array before this edge's writes land, which gives read-first behaviour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_rdata  <= '0;
         o_rdata2 <= '0;
      end else begin
         o_rdata  <= mem[i_raddr];
         o_rdata2 <= mem[i_raddr2];
      end
   end

endmodule

// File: tb/tb_cache_bank_double_access.sv
// Directed table-driven bench for cache_bank_double_access, with hand sequences for reset and hold.
module tb_cache_bank_double_access;

   localparam int DW = 32;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          we, we2;
   logic [DW-1:0] wdata, wdata2;
   logic [AW-1:0] waddr, raddr, waddr2, raddr2;
   logic [DW-1:0] rdata, rdata2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          we;
      logic [DW-1:0] wdata;
      logic [AW-1:0] waddr;
      logic [AW-1:0] raddr;
      logic          we2;
      logic [DW-1:0] wdata2;
      logic [AW-1:0] waddr2;
      logic [AW-1:0] raddr2;
      logic          chk;
      logic [DW-1:0] exp1;
      logic [DW-1:0] exp2;
      string         name;
   } vec_t;

   vec_t vecs[13];

   cache_bank_double_access #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_we(we), .i_wdata(wdata), .i_waddr(waddr), .i_raddr(raddr), .o_rdata(rdata),
      .i_we2(we2), .i_wdata2(wdata2), .i_waddr2(waddr2), .i_raddr2(raddr2), .o_rdata2(rdata2)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic w1, input logic [DW-1:0] d1, input logic [AW-1:0] wa1,
                               input logic [AW-1:0] ra1, input logic w2, input logic [DW-1:0] d2,
                               input logic [AW-1:0] wa2, input logic [AW-1:0] ra2, input logic c,
                               input logic [DW-1:0] e1, input logic [DW-1:0] e2, input string n);
      vec_t v;
      v.we = w1; v.wdata = d1; v.waddr = wa1; v.raddr = ra1;
      v.we2 = w2; v.wdata2 = d2; v.waddr2 = wa2; v.raddr2 = ra2;
      v.chk = c; v.exp1 = e1; v.exp2 = e2; v.name = n;
      return v;
   endfunction

   task automatic drive(input logic w1, input logic [DW-1:0] d1, input logic [AW-1:0] wa1,
                        input logic [AW-1:0] ra1, input logic w2, input logic [DW-1:0] d2,
                        input logic [AW-1:0] wa2, input logic [AW-1:0] ra2);
      we = w1; wdata = d1; waddr = wa1; raddr = ra1;
      we2 = w2; wdata2 = d2; waddr2 = wa2; raddr2 = ra2;
   endtask

   initial begin
      // Each row is one cycle; the expected values are the outputs just after that cycle's edge.
      vecs[0]  = mk(1, 32'hDEADBEEF, 5, 0, 1, 32'h12345678, 63, 0, 0, 0, 0, "wr_p1_5_p2_63");
      vecs[1]  = mk(0, 0, 0, 63, 0, 0, 0, 5, 1, 32'h12345678, 32'hDEADBEEF, "basic_rd");
      vecs[2]  = mk(1, 32'hA, 1, 5, 1, 32'hB, 2, 63, 1, 32'hDEADBEEF, 32'h12345678, "dual_wr");
      vecs[3]  = mk(0, 0, 0, 1, 0, 0, 0, 2, 1, 32'hA, 32'hB, "dual_rd");
      vecs[4]  = mk(1, 32'h1111, 7, 2, 1, 32'h2222, 7, 1, 1, 32'hB, 32'hA, "collide_wr");
      vecs[5]  = mk(0, 0, 0, 7, 0, 0, 0, 7, 1, 32'h1111, 32'h1111, "collide_rd");
      vecs[6]  = mk(1, 32'h55, 3, 7, 0, 0, 0, 1, 1, 32'h1111, 32'hA, "wr_3_55");
      vecs[7]  = mk(0, 0, 0, 3, 1, 32'h66, 3, 3, 1, 32'h55, 32'h55, "rdw_p2_old");
      vecs[8]  = mk(0, 0, 0, 3, 0, 0, 0, 3, 1, 32'h66, 32'h66, "rdw_p2_new");
      vecs[9]  = mk(1, 32'h77, 3, 3, 0, 0, 0, 3, 1, 32'h66, 32'h66, "rdw_p1_old");
      vecs[10] = mk(0, 0, 0, 3, 0, 0, 0, 3, 1, 32'h77, 32'h77, "rdw_p1_new");
      vecs[11] = mk(1, 32'h0, 0, 5, 1, 32'hFFFFFFFF, 62, 1, 1, 32'hDEADBEEF, 32'hA, "wr_0_62");
      vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 62, 1, 32'h0, 32'hFFFFFFFF, "rd_0_62");

      // Power-up reset
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      check("reset_rd1", rdata, 0);
      check("reset_rd2", rdata2, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].we, vecs[i].wdata, vecs[i].waddr, vecs[i].raddr,
               vecs[i].we2, vecs[i].wdata2, vecs[i].waddr2, vecs[i].raddr2);
         @(posedge clk);
         #1;
         if (vecs[i].chk) begin
            check({vecs[i].name, "_rd1"}, rdata, vecs[i].exp1);
            check({vecs[i].name, "_rd2"}, rdata2, vecs[i].exp2);
         end
      end

      // Outputs are registered: an address change between edges must not show through.
      @(negedge clk);
      drive(0, 0, 0, 5, 0, 0, 0, 63);
      @(posedge clk);
      #1;
      raddr = 1; raddr2 = 2;
      #2;
      check("hold_rd1", rdata, 32'hDEADBEEF);
      check("hold_rd2", rdata2, 32'h12345678);

      // Asynchronous reset mid-cycle with nonzero outputs
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_rd1", rdata, 0);
      check("async_rst_rd2", rdata2, 0);

      // Writes are blocked while reset is held, and the outputs stay cleared.
      drive(1, 32'h99999999, 5, 5, 1, 32'h88888888, 1, 1);
      @(posedge clk);
      #1;
      check("rst_hold_rd1", rdata, 0);
      check("rst_hold_rd2", rdata2, 0);

      // The first edge after release does a normal read and write; contents survive reset.
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 32'hCAFE, 9, 5, 0, 0, 0, 1);
      @(posedge clk);
      #1;
      check("post_rst_rd1", rdata, 32'hDEADBEEF);
      check("post_rst_rd2", rdata2, 32'hA);
      @(negedge clk);
      drive(0, 0, 0, 9, 0, 0, 0, 9);
      @(posedge clk);
      #1;
      check("post_rst_wr_rd1", rdata, 32'hCAFE);
      check("post_rst_wr_rd2", rdata2, 32'hCAFE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_bank_double_access.md
CACHE_BANK_DOUBLE_ACCESS -- requirements
Module: cache_bank_double_access

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width in bits of one stored word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, number of address bits; depth is 2^ADDR_WIDTH entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_we, input, 1 bit: port-1 write enable.
REQ-006 SHALL have port i_wdata, input, DATA_WIDTH bits: port-1 write data.
REQ-007 SHALL have port i_waddr, input, ADDR_WIDTH bits: port-1 write address.
REQ-008 SHALL have port i_raddr, input, ADDR_WIDTH bits: port-1 read address.
REQ-009 SHALL have port o_rdata, output, DATA_WIDTH bits: port-1 registered read data.
REQ-010 SHALL have ports i_we2, i_wdata2, i_waddr2, i_raddr2 and o_rdata2 with the same directions, widths and meanings as REQ-005 to REQ-009, for port 2.

Function
REQ-011 SHALL store 2^ADDR_WIDTH words of DATA_WIDTH bits, shared by both ports.
REQ-012 SHALL write i_wdata to entry i_waddr at a rising clk edge when i_we=1 and rst_n=1.
REQ-013 SHALL write i_wdata2 to entry i_waddr2 at a rising clk edge when i_we2=1 and rst_n=1.
REQ-014 Both ports SHALL write in the same cycle when their addresses differ.
REQ-015 Write-write collision (i_we=i_we2=1, i_waddr=i_waddr2): port 1 SHALL win; the entry holds i_wdata after the edge.
REQ-016 Reads SHALL be synchronous, one-cycle latency: o_rdata takes mem[i_raddr] at each rising edge, and o_rdata2 takes mem[i_raddr2].
REQ-017 Read ports SHALL be unconditional, with no read enable; both ports MAY read the same address in the same cycle and each returns the same word.
REQ-018 Read-during-write to the same address on the same edge, from either write port, SHALL return the old contents (read-first).
REQ-019 o_rdata and o_rdata2 SHALL hold their values between edges; the outputs are registers, not combinational paths from the address inputs.
REQ-020 No write SHALL occur while rst_n=0.

Reset
REQ-021 rst_n=0 SHALL clear o_rdata and o_rdata2 to 0 immediately, without waiting for a clock edge, and hold them at 0 while asserted.
REQ-022 Reset SHALL NOT clear the storage array; its contents are undefined after power-up and are preserved across reset.
REQ-023 After rst_n deasserts, the first rising edge SHALL perform normal reads and writes.

Structure
REQ-024 SHALL be a single flat module with no sub-modules and no package dependency.
REQ-025 SHALL reject DATA_WIDTH<1 or ADDR_WIDTH<1 at elaboration.
REQ-026 The storage array SHALL be inferable as RAM, with the output registers separate from the array.

Verification
REQ-027 Reset: drive rst_n=0 mid-cycle after reads returned nonzero -> o_rdata=o_rdata2=0 before the next edge.
REQ-028 Basic port-1 write: write 0xDEADBEEF at addr 5 via port 1, then set i_raddr2=5 -> o_rdata2=0xDEADBEEF one edge later.
REQ-029 Basic port-2 write: write 0x12345678 at addr 63 via port 2, then set i_raddr=63 -> o_rdata=0x12345678 one edge later.
REQ-030 Dual write, different addresses: port 1 writes 0xA at addr 1 and port 2 writes 0xB at addr 2 in the same cycle -> subsequent reads return 0xA and 0xB.
REQ-031 Write collision: both ports write addr 7 in the same cycle (port 1 0x1111, port 2 0x2222) -> a later read of addr 7 returns 0x1111.
REQ-032 Read-during-write: addr 3 holds 0x55; on one edge write 0x66 to addr 3 while reading addr 3 on both ports -> both outputs show 0x55, and the next edge shows 0x66.
